reg_bank_reader: RTL

- Read-side sweep engine for the flat register bank. The bank exposes register i at bits [i*DATA_WIDTH +: DATA_WIDTH] of its read bus.
- On a start request, walks a contiguous (wrapping) range of registers and streams each value out over a valid/ready handshake, one beat per cycle at full throughput.
- Used for debug dumps and context save of the processor's register bank. It never writes the bank.

---
 rtl/reg_bank_reader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/reg_bank_reader.sv
// Read-side sweep engine for the flat register bank: walks a wrapping range of
// registers and streams each value out over a valid/ready handshake.
module reg_bank_reader #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REG    = 32,
  localparam int IDX_W      = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REG*DATA_WIDTH-1:0] i_read_data,
  input  logic                          i_start,
  input  logic [IDX_W-1:0]              i_first,
  input  logic [IDX_W:0]                i_count,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [IDX_W-1:0]              o_index,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_done
);

  // state  | meaning
  // IDLE   | waiting for i_start
  // SEND   | a beat is presented; advance on each transfer
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  localparam logic [IDX_W:0]   NUM_REG_C = (IDX_W+1)'(NUM_REG);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REG - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [IDX_W:0]        rem_q, rem_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] bank [NUM_REG];
  logic [IDX_W-1:0]      first_eff;
  logic [IDX_W:0]        count_eff;
  logic [IDX_W-1:0]      next_idx;

  for (genvar g = 0; g < NUM_REG; g++) begin : g_bank
    assign bank[g] = i_read_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign first_eff = ({1'b0, i_first} >= NUM_REG_C) ? '0 : i_first;
  assign count_eff = (i_count > NUM_REG_C) ? NUM_REG_C : i_count;
  // Explicit wrap so non-power-of-2 banks never index past the last register
  assign next_idx  = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      index_q <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      index_q <= index_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    index_d = index_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (count_eff == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEND;
            data_d  = bank[first_eff];
            index_d = first_eff;
            valid_d = 1'b1;
            last_d  = (count_eff == CNT_ONE);
            rem_d   = count_eff - 1'b1;
          end
        end
      end
      S_SEND: begin
        if (valid_q && i_ready) begin
          if (rem_q != '0) begin
            data_d  = bank[next_idx];
            index_d = next_idx;
            last_d  = (rem_q == CNT_ONE);
            rem_d   = rem_q - 1'b1;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_index = index_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
